kamus_mem_stage: RTL and testbench

Memory-access stage of the kamus-v core. It sits between EX and WB and owns the MEM/WB pipeline register. It takes EX results, runs loads and stores against L1D through a request/grant/rvalid handshake, and aligns and extends load data. It presents ALU result, load data, mux select, rd address and write enable to the WB stage. The pipeline stalls upstream while an L1D access is outstanding.

---
 rtl/kamus_pkg.sv | 55 +++++
 rtl/kamus_load_align.sv | 31 +++
 rtl/kamus_mem_stage.sv | 236 +++++++++++++++++++++++
 tb/tb_kamus_mem_stage.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/kamus_pkg.sv
// Shared types and helpers for the kamus-v core: memory access sizes, MEM
// stage FSM states, WB select encoding and L1D store/alignment helpers.
package kamus_pkg;

  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10
  } mem_size_e;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'b00,
    MEM_REQ  = 2'b01,
    MEM_RSP  = 2'b10
  } mem_state_e;

  typedef enum logic [1:0] {
    ALU_RESULT = 2'b00,
    MEM_RESULT = 2'b01
  } wb_sel_e;

  function automatic logic [3:0] store_be(input mem_size_e size, input logic [1:0] lo);
    case (size)
      MEM_B:   return 4'b0001 << lo;
      MEM_H:   return 4'b0011 << lo;
      default: return 4'b1111;
    endcase
  endfunction

  // Narrow stores replicate the datum so L1D can pick any lane via byte enables.
  function automatic logic [31:0] store_wdata(input mem_size_e size, input logic [31:0] d);
    case (size)
      MEM_B:   return {4{d[7:0]}};
      MEM_H:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] lo);
    case (size)
      MEM_B:   return 1'b0;
      MEM_H:   return lo[0];
      default: return (lo != 2'b00);
    endcase
  endfunction

  function automatic logic [31:0] force_align(input mem_size_e size, input logic [31:0] addr);
    case (size)
      MEM_B:   return addr;
      MEM_H:   return {addr[31:1], 1'b0};
      default: return {addr[31:2], 2'b00};
    endcase
  endfunction

endpackage

// File: rtl/kamus_load_align.sv
// Load data alignment: selects the addressed byte/halfword from the L1D word
// and sign- or zero-extends it to 32 bits.
module kamus_load_align
  import kamus_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  mem_size_e   size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = 32'h0;
    data    = rdata;
    case (size)
      MEM_B: begin
        shifted = rdata >> {addr_lo, 3'b000};
        data    = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
      end
      MEM_H: begin
        shifted = rdata >> {addr_lo[1], 4'b0000};
        data    = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
      end
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/kamus_mem_stage.sv
// kamus-v MEM stage: L1D request/grant/rvalid sequencing plus the MEM/WB register.
// Define KAMUS_MISALIGN_TRAP_EN to trap misaligned accesses instead of force-aligning them.
module kamus_mem_stage
  import kamus_pkg::*;
#(
  parameter int unsigned RSP_TIMEOUT = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        ex_valid_i,
  output logic        ex_ready_o,
  input  logic [31:0] ex_rslt_i,
  input  logic [31:0] store_data_i,
  input  logic        mem_rd_i,
  input  logic        mem_wr_i,
  input  logic [1:0]  mem_size_i,
  input  logic        mem_unsigned_i,
  input  logic        regfile_wr_en_i,
  input  logic [1:0]  wb_mux_sel_i,
  input  logic [4:0]  rd_addr_i,
  output logic        l1d_req_o,
  output logic        l1d_we_o,
  output logic [31:0] l1d_addr_o,
  output logic [31:0] l1d_wdata_o,
  output logic [3:0]  l1d_be_o,
  input  logic        l1d_gnt_i,
  input  logic        l1d_rvalid_i,
  input  logic [31:0] l1d_rdata_i,
  output logic        regfile_wr_en_o,
  output logic [4:0]  rd_addr_o,
  output logic [31:0] ex_rslt_o,
  output logic [31:0] l1d_rd_data_o,
  output logic [1:0]  wb_mux_sel_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  localparam bit          TO_EN   = (RSP_TIMEOUT > 0);
  localparam int unsigned CNT_W   = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT + 1) : 1;
  localparam int unsigned TO_LAST = (RSP_TIMEOUT > 0) ? RSP_TIMEOUT - 1 : 0;

  mem_state_e state_reg, state_next;

  // Access latched at acceptance
  logic [31:0] addr_reg;
  logic [31:0] rslt_reg;
  logic [31:0] wdata_reg;
  logic [3:0]  be_reg;
  logic        we_reg;
  mem_size_e   size_reg;
  logic        unsigned_reg;
  logic        wr_en_reg;
  logic [4:0]  rd_reg;
  logic [1:0]  mux_reg;
  logic        req_reg;
  logic [CNT_W-1:0] cnt_reg;

  // MEM/WB register
  logic        wb_wr_en_reg;
  logic [4:0]  wb_rd_reg;
  logic [31:0] wb_rslt_reg;
  logic [31:0] wb_data_reg;
  logic [1:0]  wb_mux_reg;
  logic        bus_err_reg;

  mem_size_e   size_in;
  logic        is_mem;
  logic        misalign_hit;
  logic [31:0] addr_in;
  logic [31:0] load_data;

  logic fire_alu, fire_store, fire_load, start_mem, trap, timeout;

  assign size_in = mem_size_e'(mem_size_i);
  assign is_mem  = mem_rd_i | mem_wr_i;

`ifdef KAMUS_MISALIGN_TRAP_EN
  assign misalign_hit = is_mem & is_misaligned(size_in, ex_rslt_i[1:0]);
  assign addr_in      = ex_rslt_i;
`else
  assign misalign_hit = 1'b0;
  assign addr_in      = force_align(size_in, ex_rslt_i);
`endif

  kamus_load_align u_load_align (
    .rdata       (l1d_rdata_i),
    .addr_lo     (addr_reg[1:0]),
    .size        (size_reg),
    .is_unsigned (unsigned_reg),
    .data        (load_data)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_reg <= MEM_IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    fire_alu   = 1'b0;
    fire_store = 1'b0;
    fire_load  = 1'b0;
    start_mem  = 1'b0;
    trap       = 1'b0;
    timeout    = 1'b0;
    case (state_reg)
      MEM_IDLE: begin
        if (ex_valid_i) begin
          if (!is_mem) begin
            fire_alu = 1'b1;
          end else if (misalign_hit) begin
            trap = 1'b1;
          end else begin
            start_mem  = 1'b1;
            state_next = MEM_REQ;
          end
        end
      end
      MEM_REQ: begin
        if (l1d_gnt_i) begin
          if (we_reg) begin
            fire_store = 1'b1;
            state_next = MEM_IDLE;
          end else if (l1d_rvalid_i) begin
            fire_load  = 1'b1;
            state_next = MEM_IDLE;
          end else begin
            state_next = MEM_RSP;
          end
        end
      end
      MEM_RSP: begin
        if (l1d_rvalid_i) begin
          fire_load  = 1'b1;
          state_next = MEM_IDLE;
        end else if (TO_EN && (cnt_reg == CNT_W'(TO_LAST))) begin
          timeout    = 1'b1;
          state_next = MEM_IDLE;
        end
      end
      default: state_next = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_reg     <= '0;
      rslt_reg     <= '0;
      wdata_reg    <= '0;
      be_reg       <= '0;
      we_reg       <= 1'b0;
      size_reg     <= MEM_B;
      unsigned_reg <= 1'b0;
      wr_en_reg    <= 1'b0;
      rd_reg       <= '0;
      mux_reg      <= '0;
      req_reg      <= 1'b0;
      cnt_reg      <= '0;
    end else begin
      if (start_mem) begin
        addr_reg     <= addr_in;
        rslt_reg     <= ex_rslt_i;
        wdata_reg    <= store_wdata(size_in, store_data_i);
        be_reg       <= store_be(size_in, addr_in[1:0]);
        we_reg       <= mem_wr_i;
        size_reg     <= size_in;
        unsigned_reg <= mem_unsigned_i;
        wr_en_reg    <= regfile_wr_en_i;
        rd_reg       <= rd_addr_i;
        mux_reg      <= wb_mux_sel_i;
        req_reg      <= 1'b1;
      end else if (state_reg == MEM_REQ && l1d_gnt_i) begin
        req_reg <= 1'b0;
      end
      // Held at zero through REQ so it is clear on the first RSP cycle
      if (state_reg == MEM_RSP) cnt_reg <= cnt_reg + 1'b1;
      else                      cnt_reg <= '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wb_wr_en_reg <= 1'b0;
      wb_rd_reg    <= '0;
      wb_rslt_reg  <= '0;
      wb_data_reg  <= '0;
      wb_mux_reg   <= '0;
      bus_err_reg  <= 1'b0;
    end else begin
      wb_wr_en_reg <= 1'b0;
      bus_err_reg  <= timeout;
      if (fire_alu) begin
        wb_wr_en_reg <= regfile_wr_en_i;
        wb_rd_reg    <= rd_addr_i;
        wb_rslt_reg  <= ex_rslt_i;
        wb_data_reg  <= '0;
        wb_mux_reg   <= wb_mux_sel_i;
      end else if (fire_store) begin
        wb_rd_reg   <= rd_reg;
        wb_rslt_reg <= rslt_reg;
        wb_mux_reg  <= mux_reg;
      end else if (fire_load) begin
        wb_wr_en_reg <= wr_en_reg;
        wb_rd_reg    <= rd_reg;
        wb_rslt_reg  <= rslt_reg;
        wb_data_reg  <= load_data;
        wb_mux_reg   <= mux_reg;
      end
    end
  end

`ifdef KAMUS_MISALIGN_TRAP_EN
  logic misalign_reg;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) misalign_reg <= 1'b0;
    else         misalign_reg <= trap;
  end
  assign misalign_o = misalign_reg;
`else
  assign misalign_o = 1'b0;
`endif

  assign ex_ready_o      = (state_reg == MEM_IDLE);
  assign l1d_req_o       = req_reg;
  assign l1d_we_o        = we_reg;
  assign l1d_addr_o      = {addr_reg[31:2], 2'b00};
  assign l1d_wdata_o     = wdata_reg;
  assign l1d_be_o        = be_reg;
  assign regfile_wr_en_o = wb_wr_en_reg;
  assign rd_addr_o       = wb_rd_reg;
  assign ex_rslt_o       = wb_rslt_reg;
  assign l1d_rd_data_o   = wb_data_reg;
  assign wb_mux_sel_o    = wb_mux_reg;
  assign bus_err_o       = bus_err_reg;

endmodule

// File: tb/tb_kamus_mem_stage.sv
// Scoreboard bench for kamus_mem_stage: ALU ops, loads, stores, misalignment,
// response timeout and reset mid-access.
module tb_kamus_mem_stage;
  import kamus_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        ex_valid_i, ex_ready_o;
  logic [31:0] ex_rslt_i, store_data_i;
  logic        mem_rd_i, mem_wr_i, mem_unsigned_i;
  logic [1:0]  mem_size_i, wb_mux_sel_i, wb_mux_sel_o;
  logic        regfile_wr_en_i, regfile_wr_en_o;
  logic [4:0]  rd_addr_i, rd_addr_o;
  logic        l1d_req_o, l1d_we_o, l1d_gnt_i, l1d_rvalid_i;
  logic [31:0] l1d_addr_o, l1d_wdata_o, l1d_rdata_i, ex_rslt_o, l1d_rd_data_o;
  logic [3:0]  l1d_be_o;
  logic        misalign_o, bus_err_o;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [1:0]  mux;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  always #5 clk_i = ~clk_i;

  kamus_mem_stage #(.RSP_TIMEOUT(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
    .ex_rslt_i(ex_rslt_i), .store_data_i(store_data_i),
    .mem_rd_i(mem_rd_i), .mem_wr_i(mem_wr_i),
    .mem_size_i(mem_size_i), .mem_unsigned_i(mem_unsigned_i),
    .regfile_wr_en_i(regfile_wr_en_i), .wb_mux_sel_i(wb_mux_sel_i), .rd_addr_i(rd_addr_i),
    .l1d_req_o(l1d_req_o), .l1d_we_o(l1d_we_o), .l1d_addr_o(l1d_addr_o),
    .l1d_wdata_o(l1d_wdata_o), .l1d_be_o(l1d_be_o),
    .l1d_gnt_i(l1d_gnt_i), .l1d_rvalid_i(l1d_rvalid_i), .l1d_rdata_i(l1d_rdata_i),
    .regfile_wr_en_o(regfile_wr_en_o), .rd_addr_o(rd_addr_o), .ex_rslt_o(ex_rslt_o),
    .l1d_rd_data_o(l1d_rd_data_o), .wb_mux_sel_o(wb_mux_sel_o),
    .misalign_o(misalign_o), .bus_err_o(bus_err_o)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=0x%08h exp=0x%08h", tag, act, exp);
    end else begin
      $display("ok   %s = 0x%08h", tag, act);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  // Reference load extraction, written per lane rather than by shifting
  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] lo,
                                           input mem_size_e sz, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'd0: b = w[7:0];
      2'd1: b = w[15:8];
      2'd2: b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lo[1] ? w[31:16] : w[15:0];
    if (sz == MEM_B) return uns ? {24'h0, b} : {{24{b[7]}}, b};
    if (sz == MEM_H) return uns ? {16'h0, h} : {{16{h[15]}}, h};
    return w;
  endfunction

  // WB monitor: every register write must match the oldest expected entry
  always begin
    @(posedge clk_i);
    #1;
    if (rst_ni === 1'b1 && regfile_wr_en_o === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_wb_write", {27'h0, rd_addr_o}, 32'hffff_ffff);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wb_rd", {27'h0, rd_addr_o}, {27'h0, e.rd});
        chk("wb_mux", {30'h0, wb_mux_sel_o}, {30'h0, e.mux});
        if (e.mux == MEM_RESULT) chk("wb_load_data", l1d_rd_data_o, e.val);
        else                     chk("wb_alu_rslt", ex_rslt_o, e.val);
      end
    end
  end

  task automatic set_op(input logic [31:0] a, input logic rd_op, input logic wr_op,
                        input mem_size_e sz, input logic uns, input logic [4:0] rd);
    ex_valid_i      = 1'b1;
    ex_rslt_i       = a;
    mem_rd_i        = rd_op;
    mem_wr_i        = wr_op;
    mem_size_i      = sz;
    mem_unsigned_i  = uns;
    rd_addr_i       = rd;
    regfile_wr_en_i = 1'b1;
    wb_mux_sel_i    = (rd_op | wr_op) ? MEM_RESULT : ALU_RESULT;
  endtask

  task automatic clr_op();
    ex_valid_i = 1'b0;
    mem_rd_i   = 1'b0;
    mem_wr_i   = 1'b0;
  endtask

  task automatic alu_op(input logic [31:0] v, input logic [4:0] rd);
    set_op(v, 1'b0, 1'b0, MEM_W, 1'b0, rd);
    sb.push_back('{rd: rd, mux: ALU_RESULT, val: v});
    cyc();
    clr_op();
  endtask

  // Load with grant and rvalid in the first REQ cycle
  task automatic fast_load(input logic [31:0] a, input mem_size_e sz, input logic uns,
                           input logic [31:0] w, input logic [4:0] rd, input logic [31:0] exp);
    set_op(a, 1'b1, 1'b0, sz, uns, rd);
    cyc();
    clr_op();
    chk("ld_req", {31'h0, l1d_req_o}, 32'h1);
    chk("ld_addr", l1d_addr_o, {a[31:2], 2'b00});
    l1d_gnt_i = 1'b1; l1d_rvalid_i = 1'b1; l1d_rdata_i = w;
    sb.push_back('{rd: rd, mux: MEM_RESULT, val: exp});
    cyc();
    l1d_gnt_i = 1'b0; l1d_rvalid_i = 1'b0;
    chk("ld_done_ready", {31'h0, ex_ready_o}, 32'h1);
  endtask

  initial begin
    int low_cnt;
    rst_ni = 1'b0;
    clr_op();
    ex_rslt_i = 0; store_data_i = 0; mem_size_i = MEM_W; mem_unsigned_i = 0;
    regfile_wr_en_i = 0; wb_mux_sel_i = 0; rd_addr_i = 0;
    l1d_gnt_i = 0; l1d_rvalid_i = 0; l1d_rdata_i = 0;
    repeat (3) cyc();
    chk("rst_ready", {31'h0, ex_ready_o}, 32'h1);
    chk("rst_req", {31'h0, l1d_req_o}, 32'h0);
    chk("rst_wr_en", {31'h0, regfile_wr_en_o}, 32'h0);
    chk("rst_misalign", {31'h0, misalign_o}, 32'h0);
    chk("rst_bus_err", {31'h0, bus_err_o}, 32'h0);
    chk("rst_rd_data", l1d_rd_data_o, 32'h0);
    rst_ni = 1'b1;
    cyc();

    // ALU ops, back to back
    set_op(32'h1234_5678, 1'b0, 1'b0, MEM_W, 1'b0, 5'd5);
    sb.push_back('{rd: 5'd5, mux: ALU_RESULT, val: 32'h1234_5678});
    cyc();
    chk("alu_wr_en", {31'h0, regfile_wr_en_o}, 32'h1);
    chk("alu_rd_data_zero", l1d_rd_data_o, 32'h0);
    alu_op(32'hA5A5_0001, 5'd6);
    cyc();
    chk("idle_bubble", {31'h0, regfile_wr_en_o}, 32'h0);

    // LB / LBU from the test plan
    fast_load(32'h103, MEM_B, 1'b0, 32'h80FF_0000, 5'd7, 32'hFFFF_FF80);
    fast_load(32'h103, MEM_B, 1'b1, 32'h80FF_0000, 5'd8, 32'h0000_0080);

    // Byte and halfword lanes against the reference model
    for (int lo = 0; lo < 4; lo++) begin
      for (int u = 0; u < 2; u++) begin
        fast_load(32'h300 + lo, MEM_B, u[0], 32'h8A7F_C35E, 5'(10 + lo),
                  ref_load(32'h8A7F_C35E, 2'(lo), MEM_B, u[0]));
      end
    end
    for (int lo = 0; lo < 4; lo += 2) begin
      for (int u = 0; u < 2; u++) begin
        fast_load(32'h400 + lo, MEM_H, u[0], 32'h7F01_80FE, 5'(20 + lo),
                  ref_load(32'h7F01_80FE, 2'(lo), MEM_H, u[0]));
      end
    end

    // SH at 0x202 with grant delayed 3 cycles
    set_op(32'h202, 1'b0, 1'b1, MEM_H, 1'b0, 5'd9);
    store_data_i = 32'h0000_BEEF;
    cyc();
    clr_op();
    low_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (!ex_ready_o) low_cnt++;
      chk("sh_req", {31'h0, l1d_req_o}, 32'h1);
      chk("sh_be", {28'h0, l1d_be_o}, 32'hC);
      chk("sh_wdata", l1d_wdata_o, 32'hBEEF_BEEF);
      chk("sh_addr", l1d_addr_o, 32'h200);
      chk("sh_we", {31'h0, l1d_we_o}, 32'h1);
      if (i == 3) l1d_gnt_i = 1'b1;
      cyc();
    end
    l1d_gnt_i = 1'b0;
    chk("sh_ready_low_cycles", low_cnt, 4);
    chk("sh_ready_after", {31'h0, ex_ready_o}, 32'h1);
    chk("sh_req_after", {31'h0, l1d_req_o}, 32'h0);
    chk("sh_no_write", {31'h0, regfile_wr_en_o}, 32'h0);

    // LW at 0x101
    set_op(32'h101, 1'b1, 1'b0, MEM_W, 1'b0, 5'd4);
    cyc();
    clr_op();
`ifdef KAMUS_MISALIGN_TRAP_EN
    chk("mis_pulse", {31'h0, misalign_o}, 32'h1);
    chk("mis_no_req", {31'h0, l1d_req_o}, 32'h0);
    chk("mis_ready", {31'h0, ex_ready_o}, 32'h1);
    chk("mis_bubble", {31'h0, regfile_wr_en_o}, 32'h0);
    cyc();
    chk("mis_pulse_end", {31'h0, misalign_o}, 32'h0);
`else
    chk("mis_tied0", {31'h0, misalign_o}, 32'h0);
    chk("mis_req", {31'h0, l1d_req_o}, 32'h1);
    chk("mis_addr", l1d_addr_o, 32'h100);
    chk("mis_be", {28'h0, l1d_be_o}, 32'hF);
    l1d_gnt_i = 1'b1;
    cyc();
    l1d_gnt_i = 1'b0;
    chk("rsp_wait_ready", {31'h0, ex_ready_o}, 32'h0);
    chk("rsp_req_dropped", {31'h0, l1d_req_o}, 32'h0);
    l1d_rvalid_i = 1'b1; l1d_rdata_i = 32'hCAFE_F00D;
    sb.push_back('{rd: 5'd4, mux: MEM_RESULT, val: 32'hCAFE_F00D});
    cyc();
    l1d_rvalid_i = 1'b0;
`endif

    // Response timeout with RSP_TIMEOUT = 4
    set_op(32'h40, 1'b1, 1'b0, MEM_W, 1'b0, 5'd3);
    cyc();
    clr_op();
    l1d_gnt_i = 1'b1;
    cyc();
    l1d_gnt_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("to_waiting", {30'h0, ex_ready_o, bus_err_o}, 32'h0);
      cyc();
    end
    chk("to_bus_err", {31'h0, bus_err_o}, 32'h1);
    chk("to_ready", {31'h0, ex_ready_o}, 32'h1);
    chk("to_bubble", {31'h0, regfile_wr_en_o}, 32'h0);
    l1d_rvalid_i = 1'b1; l1d_rdata_i = 32'hDEAD_BEEF;
    cyc();
    l1d_rvalid_i = 1'b0;
    chk("to_pulse_end", {31'h0, bus_err_o}, 32'h0);
    chk("late_rvalid_ignored", {31'h0, regfile_wr_en_o}, 32'h0);

    // Reset while waiting in RSP
    set_op(32'h80, 1'b1, 1'b0, MEM_W, 1'b0, 5'd2);
    cyc();
    clr_op();
    l1d_gnt_i = 1'b1;
    cyc();
    l1d_gnt_i = 1'b0;
    chk("pre_rst_rsp", {31'h0, ex_ready_o}, 32'h0);
    rst_ni = 1'b0;
    #1;
    chk("rst_mid_req", {31'h0, l1d_req_o}, 32'h0);
    chk("rst_mid_wr_en", {31'h0, regfile_wr_en_o}, 32'h0);
    chk("rst_mid_ready", {31'h0, ex_ready_o}, 32'h1);
    l1d_rvalid_i = 1'b1; l1d_rdata_i = 32'h1111_2222;
    cyc();
    cyc();
    l1d_rvalid_i = 1'b0;
    rst_ni = 1'b1;
    cyc();
    alu_op(32'h0BAD_F00D, 5'd31);
    chk("post_rst_alu_rslt", ex_rslt_o, 32'h0BAD_F00D);
    cyc();

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
